// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one registered ALU through a 3-state IDLE/EXEC/RESP controller.
// Latency: accept cycle, one EXEC cycle, then the result is valid in the next cycle (II = 3 cycles).
// Backpressure: the result is held in RESP until resp_ready; no request is accepted outside IDLE.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin contention (default: requester 0 has priority).
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_ctrl,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_ctrl,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_zero,
    output logic            resp_err,
    output logic            busy
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation captured at the handshake; the ALU only ever looks at this copy.
    typedef struct packed {
        logic            id;
        logic [3:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } op_t;

    state_t          state;
    state_t          state_nxt;
    op_t             op_q;
    logic            grant1;
    logic            accept_ok;
    logic            hs;
    logic [XLEN-1:0] alu_res;
    logic            alu_err;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // 1 when requester 1 owned the most recent handshake; reset to 1 so requester 0 wins first.
    logic last_grant;

    // Contention goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant;
        end else begin
            grant1 = req1_valid;
        end
    end

    // Remember the owner of every accepted operation, contended or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (hs) begin
            last_grant <= grant1;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is not asking.
    always_comb begin
        grant1 = req1_valid & ~req0_valid;
    end
`endif

    // Readies are purely combinational and only ever point at the arbitration winner.
    assign accept_ok  = (state == IDLE) && !rst;
    assign req0_ready = accept_ok && req0_valid && !grant1;
    assign req1_ready = accept_ok && req1_valid && grant1;
    assign hs         = req0_ready | req1_ready;

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt  = state;
        resp_valid = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (hs) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winner's operands, opcode and id on the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else if (hs) begin
            if (grant1) begin
                op_q.id   <= 1'b1;
                op_q.ctrl <= req1_ctrl;
                op_q.a    <= req1_a;
                op_q.b    <= req1_b;
            end else begin
                op_q.id   <= 1'b0;
                op_q.ctrl <= req0_ctrl;
                op_q.a    <= req0_a;
                op_q.b    <= req0_b;
            end
        end
    end

    // ALU: wrap-around arithmetic, logical shifts by the low SHW bits of b, zero result on illegal opcode.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q.ctrl)
            OP_ADD:  alu_res = op_q.a + op_q.b;
            OP_SUB:  alu_res = op_q.a - op_q.b;
            OP_AND:  alu_res = op_q.a & op_q.b;
            OP_OR:   alu_res = op_q.a | op_q.b;
            OP_SLL:  alu_res = op_q.a << op_q.b[SHW-1:0];
            OP_SRL:  alu_res = op_q.a >> op_q.b[SHW-1:0];
            default: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    // Register the response during EXEC; it then holds untouched through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else if (state == EXEC) begin
            resp_id     <= op_q.id;
            resp_result <= alu_res;
            resp_zero   <= (alu_res == '0);
            resp_err    <= alu_err;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed stimulus against a reference model and response scoreboard.
// Latency: the model expects the response two cycles after the accept cycle, held until resp_ready.
// Backpressure: resp_ready is driven low for stretches to check that the response holds.
module tb_alu_arbiter;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]      req0_ctrl, req1_ctrl;
    logic            resp_valid, resp_ready, resp_id, resp_zero, resp_err, busy;
    logic [XLEN-1:0] resp_result;

    alu_arbiter #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            id;
        logic [XLEN-1:0] res;
        logic            zero;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_phase  = 0;   // 0 idle, 1 computing, 2 response presented
    logic m_last   = 1'b1;
    logic prev_rst = 1'b0;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference ALU written as plain modular arithmetic on 64-bit integers.
    function automatic exp_t model(input logic id, input logic [3:0] c,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        longint unsigned m  = 64'h1_0000_0000;
        longint unsigned la = a;
        longint unsigned lb = b;
        longint unsigned r  = 0;
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (c)
            4'b0000: r = (la + lb) % m;
            4'b0001: r = (la + m - lb) % m;
            4'b0010: r = la & lb;
            4'b0100: r = la | lb;
            4'b1000: r = (la << (lb % 32)) % m;
            4'b0011: r = la >> (lb % 32);
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.res  = r[XLEN-1:0];
        e.zero = (r == 0);
        return e;
    endfunction

    // Monitor/scoreboard: judge the current cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        logic w1, er0, er1;
        exp_t e;
        if (prev_rst) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_resp_result", resp_result, 0);
            chk("rst_resp_zero", resp_zero, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_busy", busy, 0);
        end
        if (rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            exp_q.delete();
            m_phase = 0;
            m_last  = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    chk("idle_resp_valid", resp_valid, 0);
                    chk("idle_busy", busy, 0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    w1 = (req0_valid && req1_valid) ? !m_last : req1_valid;
`else
                    w1 = req1_valid && !req0_valid;
`endif
                    er0 = req0_valid && !w1;
                    er1 = req1_valid && w1;
                    chk("arb_ready0", req0_ready, er0);
                    chk("arb_ready1", req1_ready, er1);
                    if (er0 || er1) begin
                        if (w1) e = model(1'b1, req1_ctrl, req1_a, req1_b);
                        else    e = model(1'b0, req0_ctrl, req0_a, req0_b);
                        exp_q.push_back(e);
                        m_last  = w1;
                        m_phase = 1;
                    end
                end
                1: begin
                    chk("exec_resp_valid", resp_valid, 0);
                    chk("exec_busy", busy, 1);
                    chk("exec_ready0", req0_ready, 0);
                    chk("exec_ready1", req1_ready, 0);
                    m_phase = 2;
                end
                default: begin
                    chk("resp_valid", resp_valid, 1);
                    chk("resp_busy", busy, 1);
                    chk("resp_ready0", req0_ready, 0);
                    chk("resp_ready1", req1_ready, 0);
                    if (exp_q.size() == 0) begin
                        chk("resp_queue_nonempty", 0, 1);
                    end else begin
                        chk("resp_id", resp_id, exp_q[0].id);
                        chk("resp_result", resp_result, exp_q[0].res);
                        chk("resp_zero", resp_zero, exp_q[0].zero);
                        chk("resp_err", resp_err, exp_q[0].err);
                        if (resp_ready) begin
                            void'(exp_q.pop_front());
                            m_phase = 0;
                        end
                    end
                end
            endcase
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic id, input logic [3:0] c,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bit got = 0;
        if (id) begin req1_valid = 1; req1_ctrl = c; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_ctrl = c; req0_a = a; req0_b = b; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1; break; end
        end
        tick();
        req0_valid = 0;
        req1_valid = 0;
        if (!got) chk("issue_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_phase == 0 && exp_q.size() == 0) begin ok = 1; break; end
            tick();
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    function automatic logic [3:0] rand_ctrl();
        logic [3:0] legal [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return legal[$urandom_range(0, 5)];
    endfunction

    function automatic logic [XLEN-1:0] rand_data();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1; resp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_ctrl = 0;
        req1_a = 0; req1_b = 0; req1_ctrl = 0;
        repeat (3) tick();
        rst = 0;
        tick();

        // Directed corner operations.
        issue(0, 4'b0000, 32'hFFFF_FFFF, 32'h1);
        wait_idle();
        issue(1, 4'b1000, 32'h1, 32'h21);
        wait_idle();
        issue(1, 4'b0011, 32'h8000_0000, 32'h1F);
        wait_idle();
        issue(0, 4'b0001, 32'd5, 32'd7);
        wait_idle();
        issue(0, 4'b1111, 32'h1234, 32'h5678);
        wait_idle();
        issue(0, 4'b0100, 32'hF0, 32'h0F);
        wait_idle();

        // Response held under backpressure while both requesters knock.
        resp_ready = 0;
        issue(1, 4'b0010, 32'hFF00_FF00, 32'h0FF0_0FF0);
        req0_valid = 1; req1_valid = 1;
        repeat (6) tick();
        req0_valid = 0; req1_valid = 0;
        resp_ready = 1;
        wait_idle();

        // Continuous contention with a free-flowing consumer.
        req0_valid = 1; req0_ctrl = 4'b0000; req0_a = 32'd10; req0_b = 32'd20;
        req1_valid = 1; req1_ctrl = 4'b0001; req1_a = 32'd10; req1_b = 32'd20;
        repeat (24) tick();
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        // Reset while the operation is computing: no response may emerge.
        issue(0, 4'b0000, 32'd1, 32'd2);
        rst = 1;
        tick();
        rst = 0;
        repeat (4) tick();

        // Randomized traffic, including dropped requests, illegal opcodes and rare resets.
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_ctrl = rand_ctrl(); req0_a = rand_data(); req0_b = rand_data();
            req1_ctrl = rand_ctrl(); req1_a = rand_data(); req1_b = rand_data();
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
        wait_idle();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 The block SHALL have parameter SHW, default 5, shift-amount width; SHW = log2(XLEN).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 The block SHALL have ports req0_ready / req1_ready  output  1  operation from requester n accepted this cycle.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  XLEN  operands.
REQ-008 The block SHALL have ports req0_ctrl / req1_ctrl  input  4  opcode: ADD 0000, SUB 0001, AND 0010, OR 0100, SLL 1000, SRL 0011.
REQ-009 The block SHALL have port resp_valid  output  1  result available.
REQ-010 The block SHALL have port resp_ready  input  1  consumer takes result.
REQ-011 The block SHALL have port resp_id  output  1  requester that owns the result.
REQ-012 The block SHALL have port resp_result  output  XLEN  registered ALU result.
REQ-013 The block SHALL have port resp_zero  output  1  resp_result == 0.
REQ-014 The block SHALL have port resp_err  output  1  opcode was not one of the six legal codes.
REQ-015 The block SHALL have port busy  output  1  state != IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 In IDLE, reqN_ready SHALL be asserted combinationally only for the arbitration winner, only when its reqN_valid is high; never both readies in one cycle.
REQ-018 On handshake (valid & ready) the block SHALL latch a, b, ctrl and the id, then go to EXEC.
REQ-019 In EXEC the block SHALL compute the result from latched operands, register result, zero and err, then go to RESP; EXEC lasts exactly one cycle.
REQ-020 In RESP resp_valid SHALL be 1 and resp_id/result/zero/err SHALL stay stable until resp_ready is sampled high; the block then returns to IDLE.
REQ-021 Latency: handshake at edge N yields resp_valid high after edge N+2; minimum initiation interval 3 cycles.
REQ-022 Arithmetic SHALL be modulo 2^XLEN (ADD/SUB wrap, no carry out); SLL/SRL SHALL be logical using b[SHW-1:0] only (upper b bits ignored).
REQ-023 An illegal opcode SHALL produce resp_result = 0, resp_zero = 1, resp_err = 1; legal opcodes give resp_err = 0.
REQ-024 In EXEC and RESP both readies SHALL be 0; requester inputs are ignored.
REQ-025 A request with valid dropped before handshake SHALL be discarded without side effects.
REQ-026 resp_valid and both readies SHALL be 0 outside RESP and IDLE respectively.

Reset
REQ-027 rst high at a clock edge SHALL force state IDLE, resp_valid 0, resp_id 0, resp_result 0, resp_zero 0, resp_err 0, last-grant register to 1, regardless of state (a pending or in-flight operation is dropped).
REQ-028 While rst is high, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-029 Macro ALU_ARB_ROUND_ROBIN_EN defined: when both valid in IDLE, the requester not granted last SHALL win; last-grant updates on each handshake; first contention after reset goes to requester 0.
REQ-030 ALU_ARB_ROUND_ROBIN_EN undefined: requester 0 SHALL always win contention (fixed priority); last-grant register is not implemented.

Verification
REQ-031 Req0 ADD a=0xFFFFFFFF b=0x1 -> ready0 same cycle, resp_valid 2 cycles later, result 0x0, zero 1, id 0, err 0.
REQ-032 Both valid continuously, RR enabled, resp_ready=1 -> grants alternate 0,1,0,1; RR disabled -> all grants to 0, req1 starved.
REQ-033 Req1 SLL a=0x1 b=0x21 -> result 0x2 (shift by 1); SRL a=0x80000000 b=0x1F -> 0x1; SUB 5-7 -> 0xFFFFFFFE.
REQ-034 Req0 ctrl=1111 -> result 0, zero 1, err 1; next legal op clears err.
REQ-035 resp_ready held low 5 cycles in RESP -> outputs stable, busy 1, both readies 0; ready high releases to IDLE next edge.
REQ-036 rst asserted in EXEC -> next cycle IDLE, resp_valid 0, all outputs at reset values, no response emitted.
